// File: rtl/bg_pkg.sv
// ============================================================================
// bg_pkg : shared types and constants for the banded background controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package bg_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    FLASH    = 2'd1,
    GAMEOVER = 2'd2
  } scene_state_t;

  localparam logic [7:0] FLASH_COLOR    = 8'hFF;
  localparam logic [7:0] GAMEOVER_COLOR = 8'hE0;

  // Index 0 holds band 1's top line / band 0's colour.
  localparam logic [2:0][10:0] DEF_TOPS   = {11'd420, 11'd400, 11'd200};
  localparam logic [3:0][7:0]  DEF_COLORS = {8'hEE, 8'hAE, 8'h0E, 8'h3E};

  localparam logic [2:0] ADDR_COLOR0  = 3'd0;
  localparam logic [2:0] ADDR_TOP1    = 3'd4;
  localparam logic [2:0] ADDR_ERR_CLR = 3'd7;

endpackage

`default_nettype wire

// File: rtl/bg_cfg_regfile.sv
// ============================================================================
// bg_cfg_regfile : shadow/active band registers, req/ack write port, commit
// Revision: 1.0
// ============================================================================
`default_nettype none

module bg_cfg_regfile #(
  parameter int FRAME_LAST_Y = 479
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        cfgWrReq,
  input  logic [2:0]  cfgAddr,
  input  logic [10:0] cfgData,
  output logic        cfgWrAck,
  output logic        cfgErr,
  output logic [10:0] bandTop1,
  output logic [10:0] bandTop2,
  output logic [10:0] bandTop3,
  output logic [31:0] colorNext
);
  import bg_pkg::*;

  logic [2:0][10:0] sh_top, act_top, nx_top;
  logic [3:0][7:0]  sh_col, act_col, nx_col;
  logic             wr_en, legal, commit;

  // The shadow seen by the commit already includes a write landing this cycle.
  always_comb begin
    wr_en  = cfgWrReq && !cfgWrAck;
    nx_top = sh_top;
    nx_col = sh_col;
    if (wr_en) begin
      if (!cfgAddr[2])
        nx_col[cfgAddr[1:0]] = cfgData[7:0];
      else if (cfgAddr != ADDR_ERR_CLR)
        nx_top[cfgAddr[1:0]] = cfgData;
    end
    legal     = (nx_top[0] < nx_top[1]) && (nx_top[1] < nx_top[2]) &&
                (nx_top[2] <= 11'(FRAME_LAST_Y));
    commit    = startOfFrame && legal;
    colorNext = commit ? nx_col : act_col;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sh_top   <= DEF_TOPS;
      act_top  <= DEF_TOPS;
      sh_col   <= DEF_COLORS;
      act_col  <= DEF_COLORS;
      cfgWrAck <= 1'b0;
      cfgErr   <= 1'b0;
    end else begin
      sh_top   <= nx_top;
      sh_col   <= nx_col;
      cfgWrAck <= wr_en;
      if (commit) begin
        act_top <= nx_top;
        act_col <= nx_col;
      end
      // A rejected commit outranks a simultaneous error clear.
      if (startOfFrame && !legal)
        cfgErr <= 1'b1;
      else if (wr_en && cfgAddr == ADDR_ERR_CLR)
        cfgErr <= 1'b0;
    end
  end

  assign bandTop1 = act_top[0];
  assign bandTop2 = act_top[1];
  assign bandTop3 = act_top[2];

endmodule

`default_nettype wire

// File: rtl/bg_scene_ctrl.sv
// ============================================================================
// bg_scene_ctrl : scene FSM and frame-synchronous band colour override
// Revision: 1.0
// ============================================================================
`default_nettype none

module bg_scene_ctrl #(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PERIOD = 2,
  parameter int FRAME_LAST_Y = 479
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        cfgWrReq,
  input  logic [2:0]  cfgAddr,
  input  logic [10:0] cfgData,
  output logic        cfgWrAck,
  output logic        cfgErr,
  input  logic        hitEvent,
  input  logic        gameOver,
  input  logic        gameRestart,
  output logic [10:0] bandTop1,
  output logic [10:0] bandTop2,
  output logic [10:0] bandTop3,
  output logic [7:0]  bandColor0,
  output logic [7:0]  bandColor1,
  output logic [7:0]  bandColor2,
  output logic [7:0]  bandColor3,
  output logic [1:0]  sceneState
);
  import bg_pkg::*;

  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam int PW = $clog2(FLASH_PERIOD + 1);

  scene_state_t    state, nx_state;
  logic [CW-1:0]   cnt, nx_cnt;
  logic [PW-1:0]   ph_cnt, nx_ph_cnt;
  logic            phase, nx_phase;
  logic [31:0]     color_next, col_q, col_d;

  bg_cfg_regfile #(.FRAME_LAST_Y(FRAME_LAST_Y)) u_regfile (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .cfgWrReq     (cfgWrReq),
    .cfgAddr      (cfgAddr),
    .cfgData      (cfgData),
    .cfgWrAck     (cfgWrAck),
    .cfgErr       (cfgErr),
    .bandTop1     (bandTop1),
    .bandTop2     (bandTop2),
    .bandTop3     (bandTop3),
    .colorNext    (color_next)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= NORMAL;
      cnt    <= '0;
      ph_cnt <= '0;
      phase  <= 1'b0;
      col_q  <= DEF_COLORS;
    end else begin
      state  <= nx_state;
      cnt    <= nx_cnt;
      ph_cnt <= nx_ph_cnt;
      phase  <= nx_phase;
      col_q  <= col_d;
    end
  end

  // Events are applied first; a same-cycle frame start then advances the flash.
  always_comb begin
    nx_state  = state;
    nx_cnt    = cnt;
    nx_ph_cnt = ph_cnt;
    nx_phase  = phase;
    if (gameOver) begin
      nx_state = GAMEOVER;
    end else begin
      case (state)
        NORMAL: if (hitEvent) begin
          nx_state  = FLASH;
          nx_cnt    = CW'(FLASH_FRAMES);
          nx_ph_cnt = '0;
          nx_phase  = 1'b1;
        end
        FLASH:    if (hitEvent) nx_cnt = CW'(FLASH_FRAMES);
        GAMEOVER: if (gameRestart) nx_state = NORMAL;
        default:  nx_state = NORMAL;
      endcase
    end
    if (startOfFrame && nx_state == FLASH) begin
      nx_cnt = nx_cnt - CW'(1);
      if (nx_ph_cnt == PW'(FLASH_PERIOD)) begin
        nx_phase  = ~nx_phase;
        nx_ph_cnt = PW'(1);
      end else begin
        nx_ph_cnt = nx_ph_cnt + PW'(1);
      end
      if (nx_cnt == '0) nx_state = NORMAL;
    end
  end

  always_comb begin
    col_d = col_q;
    if (startOfFrame) begin
      case (nx_state)
        GAMEOVER: col_d = {4{GAMEOVER_COLOR}};
        FLASH:    col_d = nx_phase ? {4{FLASH_COLOR}} : color_next;
        default:  col_d = color_next;
      endcase
    end
  end

  assign sceneState = state;
  assign bandColor0 = col_q[7:0];
  assign bandColor1 = col_q[15:8];
  assign bandColor2 = col_q[23:16];
  assign bandColor3 = col_q[31:24];

endmodule

`default_nettype wire

// File: tb/tb_bg_scene_ctrl.sv
// ============================================================================
// tb_bg_scene_ctrl : directed + randomized bench with a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bg_scene_ctrl;

  localparam int FLASH_FRAMES = 8;
  localparam int FLASH_PERIOD = 2;
  localparam int FRAME_LAST_Y = 479;

  logic        clk, resetN, startOfFrame, cfgWrReq, hitEvent, gameOver, gameRestart;
  logic [2:0]  cfgAddr;
  logic [10:0] cfgData;
  logic        cfgWrAck, cfgErr;
  logic [10:0] bandTop1, bandTop2, bandTop3;
  logic [7:0]  bandColor0, bandColor1, bandColor2, bandColor3;
  logic [1:0]  sceneState;

  bg_scene_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES), .FLASH_PERIOD(FLASH_PERIOD), .FRAME_LAST_Y(FRAME_LAST_Y)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .cfgWrReq(cfgWrReq), .cfgAddr(cfgAddr), .cfgData(cfgData),
    .cfgWrAck(cfgWrAck), .cfgErr(cfgErr),
    .hitEvent(hitEvent), .gameOver(gameOver), .gameRestart(gameRestart),
    .bandTop1(bandTop1), .bandTop2(bandTop2), .bandTop3(bandTop3),
    .bandColor0(bandColor0), .bandColor1(bandColor1),
    .bandColor2(bandColor2), .bandColor3(bandColor3),
    .sceneState(sceneState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Behavioural model: scene is 0 normal / 1 flash / 2 game-over;
  // m_p counts flash frames shown so far, used to pick the flash phase.
  int m_sh_top[3], m_act_top[3], m_sh_col[4], m_act_col[4], m_out[4];
  bit m_ack, m_err;
  int m_st, m_cnt, m_p;

  task automatic m_reset();
    m_sh_top  = '{200, 400, 420};
    m_act_top = '{200, 400, 420};
    m_sh_col  = '{'h3E, 'h0E, 'hAE, 'hEE};
    m_act_col = '{'h3E, 'h0E, 'hAE, 'hEE};
    m_out     = '{'h3E, 'h0E, 'hAE, 'hEE};
    m_ack = 0; m_err = 0; m_st = 0; m_cnt = 0; m_p = 0;
  endtask

  task automatic m_step();
    bit wr, legal, ff;
    int a;
    a  = int'(cfgAddr);
    wr = cfgWrReq && !m_ack;
    if (wr) begin
      if (a < 4) m_sh_col[a] = int'(cfgData) & 'hFF;
      else if (a < 7) m_sh_top[a-4] = int'(cfgData);
      else m_err = 0;
    end
    if (startOfFrame) begin
      legal = m_sh_top[0] < m_sh_top[1] && m_sh_top[1] < m_sh_top[2] &&
              m_sh_top[2] <= FRAME_LAST_Y;
      if (legal) begin
        m_act_top = m_sh_top;
        m_act_col = m_sh_col;
      end else m_err = 1;
    end
    m_ack = wr;
    if (gameOver) m_st = 2;
    else if (m_st == 0 && hitEvent) begin m_st = 1; m_cnt = FLASH_FRAMES; m_p = 0; end
    else if (m_st == 1 && hitEvent) m_cnt = FLASH_FRAMES;
    else if (m_st == 2 && gameRestart) m_st = 0;
    if (startOfFrame) begin
      ff = 0;
      if (m_st == 1) begin
        ff = ((m_p / FLASH_PERIOD) % 2) == 0;
        m_p++;
        m_cnt--;
        if (m_cnt == 0) m_st = 0;
      end
      for (int i = 0; i < 4; i++)
        m_out[i] = (m_st == 2) ? 'hE0 : (m_st == 1 && ff) ? 'hFF : m_act_col[i];
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", cfgWrAck, m_ack);
      chk("err", cfgErr, m_err);
      chk("state", sceneState, m_st);
      chk("top1", bandTop1, m_act_top[0]);
      chk("top2", bandTop2, m_act_top[1]);
      chk("top3", bandTop3, m_act_top[2]);
      chk("col0", bandColor0, m_out[0]);
      chk("col1", bandColor1, m_out[1]);
      chk("col2", bandColor2, m_out[2]);
      chk("col3", bandColor3, m_out[3]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input bit s, input bit h, input bit g, input bit r);
    startOfFrame = s; hitEvent = h; gameOver = g; gameRestart = r;
    tick();
    startOfFrame = 0; hitEvent = 0; gameOver = 0; gameRestart = 0;
  endtask

  task automatic wr(input int a, input int d);
    cfgWrReq = 1; cfgAddr = 3'(a); cfgData = 11'(d);
    tick();
    chk("wr_ack_hi", cfgWrAck, 1);
    tick();
    chk("wr_ack_lo", cfgWrAck, 0);
    cfgWrReq = 0;
  endtask

  int flash_exp[8] = '{'hFF, 'hFF, 'h3E, 'h3E, 'hFF, 'hFF, 'h3E, 'h3E};
  int wait_cnt, a, d;

  initial begin
    resetN = 0; startOfFrame = 0; cfgWrReq = 0; cfgAddr = 0; cfgData = 0;
    hitEvent = 0; gameOver = 0; gameRestart = 0;
    repeat (3) @(posedge clk);
    #1 resetN = 1;
    chk_en = 1;

    chk("rst_top1", bandTop1, 200);
    chk("rst_top2", bandTop2, 400);
    chk("rst_top3", bandTop3, 420);
    chk("rst_col0", bandColor0, 'h3E);
    chk("rst_col1", bandColor1, 'h0E);
    chk("rst_col2", bandColor2, 'hAE);
    chk("rst_col3", bandColor3, 'hEE);
    chk("rst_state", sceneState, 0);
    chk("rst_ack", cfgWrAck, 0);

    wr(4, 150);
    chk("top1_held", bandTop1, 200);
    pulse(1, 0, 0, 0);
    chk("top1_commit", bandTop1, 150);

    wr(5, 100);
    pulse(1, 0, 0, 0);
    chk("bad_top2_kept", bandTop2, 400);
    chk("bad_err_set", cfgErr, 1);
    wr(7, 0);
    chk("err_cleared", cfgErr, 0);
    wr(5, 300);
    pulse(1, 0, 0, 0);
    chk("top2_fixed", bandTop2, 300);
    chk("err_still_clr", cfgErr, 0);

    pulse(0, 1, 0, 0);
    chk("hit_state", sceneState, 1);
    for (int k = 0; k < 8; k++) begin
      pulse(1, 0, 0, 0);
      chk("flash_col0", bandColor0, flash_exp[k]);
      chk("flash_col3", bandColor3, (flash_exp[k] == 'hFF) ? 'hFF : 'hEE);
    end
    chk("flash_done", sceneState, 0);

    pulse(0, 1, 0, 0);
    repeat (4) pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      pulse(1, 0, 0, 0);
      chk("reload_state", sceneState, 1);
    end
    pulse(1, 0, 0, 0);
    chk("reload_done", sceneState, 0);

    pulse(0, 1, 1, 0);
    chk("go_wins", sceneState, 2);
    pulse(1, 0, 0, 0);
    chk("go_col0", bandColor0, 'hE0);
    chk("go_col2", bandColor2, 'hE0);
    pulse(0, 1, 0, 0);
    chk("go_ignore_hit", sceneState, 2);
    pulse(0, 0, 0, 1);
    chk("restart_state", sceneState, 0);
    pulse(1, 0, 0, 0);
    chk("restart_col0", bandColor0, 'h3E);

    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cfgWrReq) begin
        if (cfgWrAck) begin
          cfgWrReq = 0; wait_cnt = 0;
        end else if (++wait_cnt > 3) begin
          chk("ack_timeout", 0, 1);
          cfgWrReq = 0; wait_cnt = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 7);
        case (a)
          4: d = $urandom_range(0, 220);
          5: d = $urandom_range(150, 430);
          6: d = $urandom_range(300, 500);
          default: d = $urandom_range(0, 2047);
        endcase
        cfgAddr = 3'(a); cfgData = 11'(d); cfgWrReq = 1;
      end
      startOfFrame = ($urandom_range(0, 4) == 0);
      hitEvent     = ($urandom_range(0, 14) == 0);
      gameOver     = ($urandom_range(0, 79) == 0);
      gameRestart  = ($urandom_range(0, 9) == 0);
      tick();
    end
    startOfFrame = 0; hitEvent = 0; gameOver = 0; gameRestart = 0; cfgWrReq = 0;
    tick();

    // Reset in the middle of a flash with a request not yet sampled.
    pulse(0, 1, 0, 0);
    cfgWrReq = 1; cfgAddr = 3'd4; cfgData = 11'd10;
    #2 resetN = 0;
    tick();
    cfgWrReq = 0;
    tick();
    resetN = 1;
    chk("mid_rst_ack", cfgWrAck, 0);
    chk("mid_rst_state", sceneState, 0);
    chk("mid_rst_top1", bandTop1, 200);
    chk("mid_rst_col0", bandColor0, 'h3E);
    repeat (3) tick();
    pulse(1, 0, 0, 0);
    chk("post_rst_top1", bandTop1, 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
